// File: rtl/dna2_ascii_unpacker.sv
// Streaming unpacker: packed 2-bit nucleotide words in, one ASCII base per cycle out.
// Define FASTA_NEWLINE_EN to wrap output into LINE_LEN-base lines terminated by 0x0A.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both high.
// A producer holds its payload stable while valid is high and ready is low. out_valid
// never depends on out_ready. in_ready depends combinationally on out_ready only when
// the last base of the current word is being consumed, which lets the next word load
// in the same cycle.
module dna2_ascii_unpacker #(
  parameter int BASES_PER_WORD = 8,
  parameter int LINE_LEN       = 60
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [2*BASES_PER_WORD-1:0]          in_word,
  input  logic [$clog2(BASES_PER_WORD):0]      in_nbases,
  input  logic                                 in_last,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  output logic [7:0]                           out_char,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic                                 out_last,
  output logic                                 busy
);

  localparam int WW = 2 * BASES_PER_WORD;
  localparam int CW = $clog2(BASES_PER_WORD) + 1;

  if (BASES_PER_WORD < 2 || LINE_LEN < 1) begin : g_param_check
    $error("dna2_ascii_unpacker: BASES_PER_WORD must be >= 2 and LINE_LEN >= 1");
  end

`ifdef FASTA_NEWLINE_EN
  typedef enum logic [1:0] {S_IDLE, S_EMIT, S_NL} state_t;
  localparam int COLW = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
  localparam logic [COLW-1:0] LAST_COL = COLW'(LINE_LEN - 1);
  logic [COLW-1:0] col_q, col_d;
  logic            nl_after;
`else
  typedef enum logic [1:0] {S_IDLE, S_EMIT} state_t;
`endif

  state_t          state_q, state_d;
  logic [WW-1:0]   sr_q, sr_d;
  logic [CW-1:0]   rem_q, rem_d;
  logic            last_q, last_d;
  logic            word_end;
  logic            new_word;

  function automatic logic [7:0] base_to_ascii(input logic [1:0] b);
    case (b)
      2'b00:   return 8'h41;
      2'b01:   return 8'h43;
      2'b10:   return 8'h54;
      default: return 8'h47;
    endcase
  endfunction

  assign word_end = (state_q == S_EMIT) && out_ready && (rem_q == CW'(1));
  assign new_word = in_valid && (in_nbases != '0);

`ifdef FASTA_NEWLINE_EN
  // A newline follows this base when it fills the line or closes the packet.
  assign nl_after = (col_q == LAST_COL) || last_q;
  assign in_ready = (state_q == S_IDLE) || (word_end && !nl_after);
`else
  assign in_ready = (state_q == S_IDLE) || word_end;
`endif

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    rem_d   = rem_q;
    last_d  = last_q;
`ifdef FASTA_NEWLINE_EN
    col_d   = col_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (new_word) begin
          sr_d    = in_word;
          rem_d   = in_nbases;
          last_d  = in_last;
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        if (out_ready) begin
          sr_d  = sr_q >> 2;
          rem_d = rem_q - CW'(1);
`ifdef FASTA_NEWLINE_EN
          if ((col_q == LAST_COL) || (last_q && rem_q == CW'(1))) begin
            col_d   = '0;
            state_d = S_NL;
          end else begin
            col_d = col_q + COLW'(1);
            if (rem_q == CW'(1)) begin
              if (new_word) begin
                sr_d   = in_word;
                rem_d  = in_nbases;
                last_d = in_last;
              end else begin
                state_d = S_IDLE;
              end
            end
          end
`else
          if (rem_q == CW'(1)) begin
            if (new_word) begin
              sr_d   = in_word;
              rem_d  = in_nbases;
              last_d = in_last;
            end else begin
              state_d = S_IDLE;
            end
          end
`endif
        end
      end
`ifdef FASTA_NEWLINE_EN
      S_NL: begin
        if (out_ready) begin
          state_d = (rem_q == '0) ? S_IDLE : S_EMIT;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      rem_q   <= '0;
      last_q  <= 1'b0;
`ifdef FASTA_NEWLINE_EN
      col_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      rem_q   <= rem_d;
      last_q  <= last_d;
`ifdef FASTA_NEWLINE_EN
      col_q   <= col_d;
`endif
    end
  end

  always_comb begin
    out_valid = (state_q != S_IDLE);
    busy      = (state_q != S_IDLE);
    out_char  = 8'h00;
    out_last  = 1'b0;
    if (state_q == S_EMIT) begin
      out_char = base_to_ascii(sr_q[1:0]);
`ifndef FASTA_NEWLINE_EN
      out_last = last_q && (rem_q == CW'(1));
`endif
    end
`ifdef FASTA_NEWLINE_EN
    if (state_q == S_NL) begin
      out_char = 8'h0A;
      out_last = last_q && (rem_q == '0);
    end
`endif
  end

endmodule

// File: tb/tb_dna2_ascii_unpacker.sv
// Directed bench for dna2_ascii_unpacker: per-cycle vector table plus hand-written
// sequences for async reset and (when FASTA_NEWLINE_EN is defined) line wrapping.
module tb_dna2_ascii_unpacker;

  localparam int BPW = 8;
  localparam int CW  = $clog2(BPW) + 1;

  localparam logic [7:0] CH_A = 8'h41;
  localparam logic [7:0] CH_C = 8'h43;
  localparam logic [7:0] CH_T = 8'h54;
  localparam logic [7:0] CH_G = 8'h47;

  logic              clk;
  logic              rst;
  logic [2*BPW-1:0]  in_word;
  logic [CW-1:0]     in_nbases;
  logic              in_last;
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        out_char;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              busy;

  int n_vec;
  int n_bad;

  typedef struct {
    logic [15:0]   w;
    logic [CW-1:0] nb;
    logic          lst;
    logic          vld;
    logic          rdy;
    logic [7:0]    e_char;
    logic          e_valid;
    logic          e_last;
    logic          e_in_ready;
    logic          e_busy;
  } vec_t;

  vec_t tbl[$];

  dna2_ascii_unpacker #(.BASES_PER_WORD(BPW), .LINE_LEN(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_word   (in_word),
    .in_nbases (in_nbases),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_char  (out_char),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic [15:0] w, logic [CW-1:0] nb, logic lst, logic vld,
                              logic rdy, logic [7:0] ec, logic ev, logic el, logic eir,
                              logic eb);
    vec_t v;
    v.w = w; v.nb = nb; v.lst = lst; v.vld = vld; v.rdy = rdy;
    v.e_char = ec; v.e_valid = ev; v.e_last = el; v.e_in_ready = eir; v.e_busy = eb;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [15:0] act,
                     input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  // driver: drive at posedge+1, check at negedge
  task automatic drive(input vec_t v);
    in_word   = v.w;
    in_nbases = v.nb;
    in_last   = v.lst;
    in_valid  = v.vld;
    out_ready = v.rdy;
  endtask

  task automatic apply(input vec_t v, input int idx);
    drive(v);
    @(negedge clk);
    chk("out_valid", idx, 16'(out_valid), 16'(v.e_valid));
    chk("out_char",  idx, 16'(out_char),  16'(v.e_char));
    chk("out_last",  idx, 16'(out_last),  16'(v.e_last));
    chk("in_ready",  idx, 16'(in_ready),  16'(v.e_in_ready));
    chk("busy",      idx, 16'(busy),      16'(v.e_busy));
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  vec_t idle_v;
  logic [7:0] actg[4];
  logic [7:0] gtca[4];
  logic       bp_rdy[8];
  logic [7:0] bp_chr[8];
  logic       bp_lst[8];
  logic [8:0] exp_q[$];

  initial begin
    n_vec = 0;
    n_bad = 0;
    actg = '{CH_A, CH_C, CH_T, CH_G};
    gtca = '{CH_G, CH_T, CH_C, CH_A};
    idle_v = mk(16'h0, '0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);

`ifndef FASTA_NEWLINE_EN
    // 8-base word, last: ACTGACTG, last only on the 8th
    tbl.push_back(idle_v);
    tbl.push_back(mk(16'hE4E4, CW'(8), 1, 1, 1, 8'h00, 0, 0, 1, 0));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(16'h0, '0, 0, 0, 1, actg[i % 4], 1, (i == 7), (i == 7), 1));
    tbl.push_back(idle_v);
    // zero-base word is dropped
    tbl.push_back(mk(16'hE4E4, '0, 1, 1, 1, 8'h00, 0, 0, 1, 0));
    tbl.push_back(idle_v);
    // back-to-back words with no bubble
    tbl.push_back(mk(16'h1B1B, CW'(8), 0, 1, 1, 8'h00, 0, 0, 1, 0));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(16'h5555, CW'(8), 1, 1, 1, gtca[i % 4], 1, 0, (i == 7), 1));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(16'h0, '0, 0, 0, 1, CH_C, 1, (i == 7), (i == 7), 1));
    tbl.push_back(idle_v);
    // partial word
    tbl.push_back(mk(16'h00FF, CW'(3), 1, 1, 1, 8'h00, 0, 0, 1, 0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(16'h0, '0, 0, 0, 1, CH_G, 1, (i == 2), (i == 2), 1));
    tbl.push_back(idle_v);
    // backpressure, including a stall on the final character
    bp_rdy = '{1, 0, 0, 1, 0, 1, 0, 1};
    bp_chr = '{CH_A, CH_C, CH_C, CH_C, CH_T, CH_T, CH_G, CH_G};
    bp_lst = '{0, 0, 0, 0, 0, 0, 1, 1};
    tbl.push_back(mk(16'h00E4, CW'(4), 1, 1, 1, 8'h00, 0, 0, 1, 0));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(16'h0, '0, 0, 0, bp_rdy[i], bp_chr[i], 1, bp_lst[i], (i == 7), 1));
    tbl.push_back(idle_v);
`endif

    rst = 1'b1;
    drive(idle_v);
    @(negedge clk);
    chk("rst_out_valid", 0, 16'(out_valid), 16'(0));
    chk("rst_out_char",  0, 16'(out_char),  16'(0));
    chk("rst_out_last",  0, 16'(out_last),  16'(0));
    chk("rst_busy",      0, 16'(busy),      16'(0));
    chk("rst_in_ready",  0, 16'(in_ready),  16'(1));
    next_cycle();
    rst = 1'b0;
    next_cycle();

    foreach (tbl[i]) begin
      apply(tbl[i], i);
      next_cycle();
    end

`ifndef FASTA_NEWLINE_EN
    // async reset after 3 chars of a word
    apply(mk(16'hE4E4, CW'(8), 1, 1, 1, 8'h00, 0, 0, 1, 0), 100);
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      apply(mk(16'h0, '0, 0, 0, 1, actg[i], 1, 0, 0, 1), 101 + i);
      if (i < 2) next_cycle();
    end
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", 0, 16'(out_valid), 16'(0));
    chk("arst_out_char",  0, 16'(out_char),  16'(0));
    chk("arst_busy",      0, 16'(busy),      16'(0));
    chk("arst_in_ready",  0, 16'(in_ready),  16'(1));
    next_cycle();
    rst = 1'b0;
    next_cycle();
    apply(mk(16'h1B1B, CW'(2), 1, 1, 1, 8'h00, 0, 0, 1, 0), 110);
    next_cycle();
    apply(mk(16'h0, '0, 0, 0, 1, CH_G, 1, 0, 0, 1), 111);
    next_cycle();
    apply(mk(16'h0, '0, 0, 0, 1, CH_T, 1, 1, 1, 1), 112);
    next_cycle();
    apply(idle_v, 113);
    next_cycle();
`else
    // LINE_LEN=4, 10 bases: ACTG\nACTG\nAC\n with last on the final newline
    begin
      logic [15:0]   words[2];
      logic [CW-1:0] nbs[2];
      logic          lsts[2];
      int            widx;
      int            ccnt;
      logic [8:0]    e;
      words = '{16'hE4E4, 16'h0004};
      nbs   = '{CW'(8), CW'(2)};
      lsts  = '{1'b0, 1'b1};
      for (int i = 0; i < 10; i++) begin
        exp_q.push_back({1'b0, actg[i % 4]});
        if (i == 3 || i == 7) exp_q.push_back({1'b0, 8'h0A});
      end
      exp_q.push_back({1'b1, 8'h0A});
      widx = 0;
      ccnt = 0;
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 60 && exp_q.size() > 0; cyc++) begin
        in_valid  = (widx < 2);
        in_word   = (widx < 2) ? words[widx] : 16'h0;
        in_nbases = (widx < 2) ? nbs[widx] : '0;
        in_last   = (widx < 2) ? lsts[widx] : 1'b0;
        @(negedge clk);
        if (out_valid) begin
          e = exp_q.pop_front();
          chk("fasta_char", ccnt, 16'(out_char), 16'(e[7:0]));
          chk("fasta_last", ccnt, 16'(out_last), 16'(e[8]));
          ccnt++;
        end
        if (in_valid && in_ready) widx++;
        next_cycle();
      end
      if (exp_q.size() != 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL fasta_timeout: got %0d chars pending expected 0", exp_q.size());
      end
      in_valid = 1'b0;
      @(negedge clk);
      chk("fasta_busy_end", 0, 16'(busy), 16'(0));
      next_cycle();
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
